// File: rtl/regfile_pkg.sv
// Shared types and default widths for the register file, decode and ALU blocks.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic [2:0] {
        HILO_NOP  = 3'd0,
        HILO_LOAD = 3'd1,
        HILO_MADD = 3'd2,
        HILO_MSUB = 3'd3,
        HILO_MTHI = 3'd4,
        HILO_MTLO = 3'd5
    } hilo_op_e;

endpackage

// File: rtl/regfile_hilo_if.sv
// Decode/writeback-facing bundle of the register file: GPR write, two reads, HI/LO op.
interface regfile_hilo_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [2:0]        hilo_op;
    logic [DATA_W-1:0] hilo_hi;
    logic [DATA_W-1:0] hilo_lo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output we, waddr, wdata, raddr1, raddr2, hilo_op, hilo_hi, hilo_lo,
        input  rdata1, rdata2, hi, lo
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2, hilo_op, hilo_hi, hilo_lo,
        output rdata1, rdata2, hi, lo
    );

endinterface

// File: rtl/regfile_hilo_acc.sv
// HI/LO accumulator pair: load, multiply-accumulate/subtract and single-half moves.
module hilo_acc
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] opd_hi,
    input  logic [DATA_W-1:0] opd_lo,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int ACC_W = 2 * DATA_W;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] opd;
    logic [ACC_W-1:0] acc_nxt;

    assign acc = {hi, lo};
    assign opd = {opd_hi, opd_lo};

    // Sum/difference wrap at 2*DATA_W; the carry out is intentionally dropped.
    always_comb begin
        acc_nxt = acc;
        case (hilo_op_e'(op))
            HILO_LOAD: acc_nxt = opd;
            HILO_MADD: acc_nxt = acc + opd;
            HILO_MSUB: acc_nxt = acc - opd;
            HILO_MTHI: acc_nxt = {opd_hi, lo};
            HILO_MTLO: acc_nxt = {hi, opd_lo};
            default:   acc_nxt = acc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else begin
            hi <= acc_nxt[ACC_W-1:DATA_W];
            lo <= acc_nxt[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/regfile_hilo.sv
// General-purpose register file with registered, write-first read ports and a HI/LO accumulator.
module regfile_hilo
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    regfile_hilo_if.slave  bus
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] gpr [NREGS];
    logic [DATA_W-1:0] rdata1_q;
    logic [DATA_W-1:0] rdata2_q;
    logic [DATA_W-1:0] rd1_nxt;
    logic [DATA_W-1:0] rd2_nxt;
    logic              wr_en;

    // A write to r0 is dropped entirely, so it must not feed the bypass either.
    assign wr_en = bus.we && !(ZERO_REG && (bus.waddr == '0));

    always_comb begin
        rd1_nxt = gpr[bus.raddr1];
        if (ZERO_REG && (bus.raddr1 == '0)) begin
            rd1_nxt = '0;
        end else if (wr_en && (bus.waddr == bus.raddr1)) begin
            rd1_nxt = bus.wdata;
        end
    end

    always_comb begin
        rd2_nxt = gpr[bus.raddr2];
        if (ZERO_REG && (bus.raddr2 == '0)) begin
            rd2_nxt = '0;
        end else if (wr_en && (bus.waddr == bus.raddr2)) begin
            rd2_nxt = bus.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                gpr[i] <= '0;
            end
        end else if (wr_en) begin
            gpr[bus.waddr] <= bus.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata1_q <= '0;
            rdata2_q <= '0;
        end else begin
            rdata1_q <= rd1_nxt;
            rdata2_q <= rd2_nxt;
        end
    end

    assign bus.rdata1 = rdata1_q;
    assign bus.rdata2 = rdata2_q;

    hilo_acc #(
        .DATA_W (DATA_W)
    ) u_hilo_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .op     (bus.hilo_op),
        .opd_hi (bus.hilo_hi),
        .opd_lo (bus.hilo_lo),
        .hi     (bus.hi),
        .lo     (bus.lo)
    );

endmodule

// File: tb/tb_regfile_hilo.sv
// Scoreboard bench for regfile_hilo: default 32/5/zero-reg instance plus a 16/3/no-zero-reg instance.
module tb_regfile_hilo;
    import regfile_pkg::*;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_tests;
    int   n_fail;

    regfile_hilo_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    regfile_hilo_if #(.DATA_W(16), .ADDR_W(3)) sbus ();

    regfile_hilo #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    regfile_hilo #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus)
    );

    typedef struct {
        int          due;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic [31:0] mon_act;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] actual(int sel);
        case (sel)
            0: return bus.rdata1;
            1: return bus.rdata2;
            2: return bus.hi;
            3: return bus.lo;
            4: return 32'(sbus.rdata1);
            5: return 32'(sbus.rdata2);
            6: return 32'(sbus.hi);
            default: return 32'(sbus.lo);
        endcase
    endfunction

    // Monitor: every output edge, compare all entries due on this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e   = sb.pop_front();
            mon_act = actual(mon_e.sel);
            n_tests++;
            if (mon_e.due != cyc || mon_act !== mon_e.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h (due %0d now %0d)",
                         mon_e.name, mon_act, mon_e.exp, mon_e.due, cyc);
            end
        end
    end

    task automatic expect_v(int sel, logic [31:0] v, string name);
        exp_t e;
        e.due  = cyc + 1;
        e.sel  = sel;
        e.exp  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.we      = 1'b0;
        bus.waddr   = '0;
        bus.wdata   = '0;
        bus.hilo_op = 3'd0;
        bus.hilo_hi = '0;
        bus.hilo_lo = '0;
        sbus.we      = 1'b0;
        sbus.waddr   = '0;
        sbus.wdata   = '0;
        sbus.hilo_op = 3'd0;
        sbus.hilo_hi = '0;
        sbus.hilo_lo = '0;
    endtask

    function automatic logic [15:0] sval(int i);
        return 16'h1000 + 16'(i) * 16'h0111;
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        rst_n   = 1'b0;
        idle();
        bus.raddr1  = '0;
        bus.raddr2  = '0;
        sbus.raddr1 = '0;
        sbus.raddr2 = '0;
        step();
        step();
        rst_n = 1'b1;
        chk("por_rdata1", bus.rdata1, 32'h0);
        chk("por_rdata2", bus.rdata2, 32'h0);
        chk("por_hi", bus.hi, 32'h0);
        chk("por_lo", bus.lo, 32'h0);

        // r5 = 0x1234 and hi = 7, then read back before a mid-run reset
        bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'h1234;
        bus.hilo_op = HILO_LOAD; bus.hilo_hi = 32'd7; bus.hilo_lo = 32'd0;
        expect_v(2, 32'd7, "load_hi7");
        expect_v(3, 32'd0, "load_lo0");
        step();
        idle();
        bus.raddr1 = 5'd5; bus.raddr2 = 5'd5;
        expect_v(0, 32'h1234, "r5_rd1");
        expect_v(1, 32'h1234, "r5_rd2");
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_rdata1", bus.rdata1, 32'h0);
        chk("rst_rdata2", bus.rdata2, 32'h0);
        chk("rst_hi", bus.hi, 32'h0);
        chk("rst_lo", bus.lo, 32'h0);
        step();
        rst_n = 1'b1;
        expect_v(0, 32'h0, "r5_after_rst_rd1");
        expect_v(1, 32'h0, "r5_after_rst_rd2");
        step();

        // zero register: write dropped, no bypass
        bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hDEADBEEF;
        bus.raddr1 = 5'd0; bus.raddr2 = 5'd0;
        expect_v(0, 32'h0, "r0_same_cycle_rd1");
        expect_v(1, 32'h0, "r0_same_cycle_rd2");
        step();
        idle();
        expect_v(0, 32'h0, "r0_later_rd1");
        expect_v(1, 32'h0, "r0_later_rd2");
        step();

        // same-cycle bypass
        bus.we = 1'b1; bus.waddr = 5'd10; bus.wdata = 32'h10101010;
        step();
        bus.we = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'hA5A5A5A5;
        bus.raddr1 = 5'd9; bus.raddr2 = 5'd10;
        expect_v(0, 32'hA5A5A5A5, "bypass_rd1");
        expect_v(1, 32'h10101010, "old_r10_rd2");
        step();
        idle();
        bus.raddr2 = 5'd9;
        expect_v(1, 32'hA5A5A5A5, "r9_array_rd2");
        step();

        // accumulate sequence
        bus.hilo_op = HILO_LOAD; bus.hilo_hi = 32'h0; bus.hilo_lo = 32'hFFFFFFFF;
        expect_v(2, 32'h0, "load_hi");
        expect_v(3, 32'hFFFFFFFF, "load_lo");
        step();
        bus.hilo_op = HILO_MADD; bus.hilo_hi = 32'h0; bus.hilo_lo = 32'h1;
        expect_v(2, 32'h1, "madd_carry_hi");
        expect_v(3, 32'h0, "madd_carry_lo");
        step();
        bus.hilo_op = HILO_MSUB; bus.hilo_hi = 32'h0; bus.hilo_lo = 32'h2;
        expect_v(2, 32'h0, "msub_borrow_hi");
        expect_v(3, 32'hFFFFFFFE, "msub_borrow_lo");
        step();
        bus.hilo_op = HILO_MADD; bus.hilo_hi = 32'hFFFFFFFF; bus.hilo_lo = 32'h2;
        expect_v(2, 32'h0, "madd_wrap_hi");
        expect_v(3, 32'h0, "madd_wrap_lo");
        step();
        bus.hilo_op = HILO_LOAD; bus.hilo_hi = 32'h1; bus.hilo_lo = 32'h2;
        step();
        bus.hilo_op = 3'd6; bus.hilo_hi = 32'h9; bus.hilo_lo = 32'h9;
        expect_v(2, 32'h1, "reserved6_hi");
        expect_v(3, 32'h2, "reserved6_lo");
        step();
        bus.hilo_op = 3'd7;
        expect_v(2, 32'h1, "reserved7_hi");
        expect_v(3, 32'h2, "reserved7_lo");
        step();

        // independence of GPR write and HI/LO move
        bus.we = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'h55;
        bus.hilo_op = HILO_MTHI; bus.hilo_hi = 32'h77; bus.hilo_lo = 32'h99;
        expect_v(2, 32'h77, "mthi_hi");
        expect_v(3, 32'h2, "mthi_lo_kept");
        step();
        idle();
        bus.raddr1 = 5'd3;
        bus.hilo_op = HILO_MTLO; bus.hilo_hi = 32'h66; bus.hilo_lo = 32'h88;
        expect_v(0, 32'h55, "r3_written");
        expect_v(2, 32'h77, "mtlo_hi_kept");
        expect_v(3, 32'h88, "mtlo_lo");
        step();
        idle();

        // 16-bit / 8-register instance without a zero register
        for (int i = 0; i < 8; i++) begin
            sbus.we = 1'b1; sbus.waddr = 3'(i); sbus.wdata = sval(i);
            step();
        end
        sbus.we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sbus.raddr1 = 3'(i); sbus.raddr2 = 3'(7 - i);
            expect_v(4, 32'(sval(i)), "s_sweep_rd1");
            expect_v(5, 32'(sval(7 - i)), "s_sweep_rd2");
            step();
        end
        sbus.we = 1'b1; sbus.waddr = 3'd0; sbus.wdata = 16'hBEEF;
        sbus.raddr1 = 3'd0; sbus.raddr2 = 3'd1;
        expect_v(4, 32'h0000BEEF, "s_r0_bypass");
        expect_v(5, 32'h00001111, "s_r1_kept");
        step();
        sbus.we = 1'b0;
        sbus.hilo_op = HILO_LOAD; sbus.hilo_hi = 16'hFFFF; sbus.hilo_lo = 16'hFFFF;
        expect_v(4, 32'h0000BEEF, "s_r0_array");
        expect_v(6, 32'h0000FFFF, "s_load_hi");
        expect_v(7, 32'h0000FFFF, "s_load_lo");
        step();
        sbus.hilo_op = HILO_MADD; sbus.hilo_hi = 16'h0; sbus.hilo_lo = 16'h1;
        expect_v(6, 32'h0, "s_madd_ovf_hi");
        expect_v(7, 32'h0, "s_madd_ovf_lo");
        step();
        sbus.hilo_op = HILO_MSUB; sbus.hilo_hi = 16'h0; sbus.hilo_lo = 16'h1;
        expect_v(6, 32'h0000FFFF, "s_msub_unf_hi");
        expect_v(7, 32'h0000FFFF, "s_msub_unf_lo");
        step();
        idle();

        for (int k = 0; k < 10 && sb.size() > 0; k++) step();
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s: got no sample expected %h", mon_e.name, mon_e.exp);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
